// File: rtl/sigma_bus_arbiter.sv
// rtl/sigma_bus_arbiter.sv - round-robin slave bus arbiter with in-order read response routing
// Optional: SIGMA_ARB_UDM_PRIO_EN lets master 0 (UDM) win whenever no grant is held.
module sigma_bus_arbiter #(
    parameter int NUM_REQ    = 3,
    parameter int RESP_DEPTH = 4
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic [NUM_REQ-1:0]     req_i,
    input  logic [NUM_REQ-1:0]     we_i,
    input  logic [NUM_REQ*32-1:0]  addr_bi,
    input  logic [NUM_REQ*4-1:0]   be_bi,
    input  logic [NUM_REQ*32-1:0]  wdata_bi,
    output logic [NUM_REQ-1:0]     ack_o,
    output logic [NUM_REQ-1:0]     resp_o,
    output logic [31:0]            rdata_bo,
    output logic                   req_o,
    output logic                   we_o,
    output logic [31:0]            addr_bo,
    output logic [3:0]             be_bo,
    output logic [31:0]            wdata_bo,
    input  logic                   ack_i,
    input  logic                   resp_i,
    input  logic [31:0]            rdata_bi,
    output logic                   err_o
);

    localparam int IDW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int PW  = (RESP_DEPTH > 1) ? $clog2(RESP_DEPTH) : 1;

    logic [IDW-1:0] rr_ptr;
    logic           hold;
    logic [IDW-1:0] held_idx;
    logic [IDW-1:0] fifo_mem [RESP_DEPTH];
    logic [PW-1:0]  wr_ptr;
    logic [PW-1:0]  rd_ptr;
    logic [PW:0]    cnt;

    logic [IDW-1:0] rr_sel;
    logic [IDW-1:0] cand;
    logic           found;
    logic [IDW-1:0] g;
    logic [IDW-1:0] next_ptr;
    logic [IDW-1:0] head;
    logic           full;
    logic           accept;
    logic           push;
    logic           pop;

    function automatic logic [IDW-1:0] wrap_add(input logic [IDW-1:0] base, input int off);
        int s;
        s = int'(base) + off;
        if (s >= NUM_REQ) s = s - NUM_REQ;
        return s[IDW-1:0];
    endfunction

    // Round-robin scan starting at rr_ptr; first requester found wins.
    always_comb begin
        rr_sel = rr_ptr;
        cand   = '0;
        found  = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            cand = wrap_add(rr_ptr, i);
            if (!found && req_i[cand]) begin
                rr_sel = cand;
                found  = 1'b1;
            end
        end
    end

    // A stalled grant is never pre-empted, even by the debug master.
    always_comb begin
        if (hold) begin
            g = held_idx;
        end else begin
`ifdef SIGMA_ARB_UDM_PRIO_EN
            if (req_i[0]) g = '0;
            else          g = rr_sel;
`else
            g = rr_sel;
`endif
        end
    end

    assign full     = (cnt == (PW+1)'(RESP_DEPTH));
    assign req_o    = !rst_i && (|req_i) && !full;
    assign we_o     = req_o & we_i[g];
    assign addr_bo  = req_o ? addr_bi[int'(g)*32 +: 32]  : '0;
    assign be_bo    = req_o ? be_bi[int'(g)*4 +: 4]      : '0;
    assign wdata_bo = req_o ? wdata_bi[int'(g)*32 +: 32] : '0;
    assign rdata_bo = rdata_bi;

    assign accept   = req_o & ack_i;
    assign push     = accept & ~we_o;
    assign pop      = !rst_i && resp_i && (cnt != '0);
    assign head     = fifo_mem[rd_ptr];
    assign next_ptr = (g == IDW'(NUM_REQ-1)) ? '0 : g + IDW'(1);

    always_comb begin
        ack_o  = '0;
        resp_o = '0;
        if (accept) ack_o[g]   = 1'b1;
        if (pop)    resp_o[head] = 1'b1;
    end

    always_ff @(posedge clk_i) begin
        if (push) fifo_mem[wr_ptr] <= g;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rr_ptr   <= '0;
            hold     <= 1'b0;
            held_idx <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            cnt      <= '0;
            err_o    <= 1'b0;
        end else begin
            if (accept) begin
                rr_ptr <= next_ptr;
                hold   <= 1'b0;
            end else if (req_o) begin
                hold     <= 1'b1;
                held_idx <= g;
            end
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
            if (push && !pop)      cnt <= cnt + (PW+1)'(1);
            else if (pop && !push) cnt <= cnt - (PW+1)'(1);
            // Responses with nothing outstanding (including ones lost to a reset) are sticky errors.
            if (resp_i && (cnt == '0)) err_o <= 1'b1;
        end
    end

endmodule

// File: tb/tb_sigma_bus_arbiter.sv
// tb/tb_sigma_bus_arbiter.sv - self-checking bench for sigma_bus_arbiter
module tb_sigma_bus_arbiter;

    localparam int N = 3;
    localparam int D = 4;

    logic            clk = 1'b0;
    logic            rst_i;
    logic [N-1:0]    req_i;
    logic [N-1:0]    we_i;
    logic [N*32-1:0] addr_bi;
    logic [N*4-1:0]  be_bi;
    logic [N*32-1:0] wdata_bi;
    logic [N-1:0]    ack_o;
    logic [N-1:0]    resp_o;
    logic [31:0]     rdata_bo;
    logic            req_o;
    logic            we_o;
    logic [31:0]     addr_bo;
    logic [3:0]      be_bo;
    logic [31:0]     wdata_bo;
    logic            ack_i;
    logic            resp_i;
    logic [31:0]     rdata_bi;
    logic            err_o;

    int checks = 0;
    int errors = 0;

    // Reference state: round-robin start, held grant, outstanding read owners.
    int m_rr;
    bit m_hold;
    int m_held;
    int m_q[$];
    bit m_err;

`ifdef SIGMA_ARB_UDM_PRIO_EN
    int t2_idx[4] = '{0, 0, 0, 0};
    logic [N-1:0] t6_ack = 3'b001;
`else
    int t2_idx[4] = '{0, 1, 2, 0};
    logic [N-1:0] t6_ack = 3'b010;
`endif
    int t4_owner[4] = '{2, 0, 1, 2};

    sigma_bus_arbiter #(.NUM_REQ(N), .RESP_DEPTH(D)) dut (
        .clk_i(clk), .rst_i(rst_i), .req_i(req_i), .we_i(we_i),
        .addr_bi(addr_bi), .be_bi(be_bi), .wdata_bi(wdata_bi),
        .ack_o(ack_o), .resp_o(resp_o), .rdata_bo(rdata_bo),
        .req_o(req_o), .we_o(we_o), .addr_bo(addr_bo), .be_bo(be_bo), .wdata_bo(wdata_bo),
        .ack_i(ack_i), .resp_i(resp_i), .rdata_bi(rdata_bi), .err_o(err_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_rr = 0; m_hold = 0; m_held = 0; m_err = 0;
        m_q.delete();
    endtask

    task automatic set_m(input int k, input logic we, input logic [31:0] addr);
        we_i[k] = we;
        addr_bi[k*32 +: 32]  = addr;
        be_bi[k*4 +: 4]      = 4'(k + 5);
        wdata_bi[k*32 +: 32] = 32'hA000_0000 + 32'(k);
    endtask

    // Predict outputs from the arbitration rules, compare, then advance one clock.
    task automatic cycle();
        int g;
        bit found, any, full, ereq, accept, pop;
        logic [N-1:0] eack, eresp;
        #1;
        g = 0;
        found = 0;
        if (m_hold) begin
            g = m_held;
        end else begin
`ifdef SIGMA_ARB_UDM_PRIO_EN
            if (req_i[0]) begin g = 0; found = 1; end
`endif
            for (int off = 0; off < N; off++)
                if (!found && req_i[(m_rr + off) % N]) begin
                    g = (m_rr + off) % N;
                    found = 1;
                end
        end
        any    = |req_i;
        full   = (m_q.size() == D);
        ereq   = !rst_i && any && !full;
        accept = ereq && ack_i;
        pop    = !rst_i && resp_i && (m_q.size() > 0);
        eack   = accept ? N'(1 << g) : '0;
        eresp  = pop ? N'(1 << m_q[0]) : '0;
        chk("req_o", 32'(req_o), 32'(ereq));
        chk("ack_o", 32'(ack_o), 32'(eack));
        chk("resp_o", 32'(resp_o), 32'(eresp));
        chk("we_o", 32'(we_o), ereq ? 32'(we_i[g]) : 32'd0);
        chk("addr_bo", addr_bo, ereq ? addr_bi[g*32 +: 32] : 32'd0);
        chk("be_bo", 32'(be_bo), ereq ? 32'(be_bi[g*4 +: 4]) : 32'd0);
        chk("wdata_bo", wdata_bo, ereq ? wdata_bi[g*32 +: 32] : 32'd0);
        chk("rdata_bo", rdata_bo, rdata_bi);
        chk("err_o", 32'(err_o), 32'(m_err));
        @(posedge clk);
        if (rst_i) begin
            model_reset();
        end else begin
            if (resp_i && m_q.size() == 0) m_err = 1;
            if (pop) void'(m_q.pop_front());
            if (accept) begin
                m_rr = (g + 1) % N;
                m_hold = 0;
                if (!we_i[g]) m_q.push_back(g);
            end else if (ereq) begin
                m_hold = 1;
                m_held = g;
            end
        end
        @(negedge clk);
    endtask

    initial begin
        model_reset();
        rst_i = 1; req_i = '1; we_i = '1; ack_i = 1; resp_i = 0; rdata_bi = 32'h1234_5678;
        addr_bi = '0; be_bi = '0; wdata_bi = '0;
        for (int k = 0; k < N; k++) set_m(k, 1'b1, 32'h1000_0000 + 32'(4 * k));
        @(posedge clk);
        @(negedge clk);

        // T1: held in reset with every master requesting.
        repeat (3) begin
            #1;
            chk("t1_req_o", 32'(req_o), 32'd0);
            chk("t1_ack_o", 32'(ack_o), 32'd0);
            chk("t1_err_o", 32'(err_o), 32'd0);
            chk("t1_rdata", rdata_bo, 32'h1234_5678);
            cycle();
        end
        rst_i = 0;

        // T2: all masters writing, slave always ready.
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("t2_ack", 32'(ack_o), 32'(1 << t2_idx[i]));
            chk("t2_addr", addr_bo, 32'h1000_0000 + 32'(4 * t2_idx[i]));
            cycle();
        end

        // T3: master 1 read stalls; master 0 joins but cannot steal the grant.
        req_i = 3'b010; ack_i = 0;
        set_m(1, 1'b0, 32'h8000_0004);
        set_m(0, 1'b1, 32'h0000_0100);
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("t3_addr_hold", addr_bo, 32'h8000_0004);
            chk("t3_ack_zero", 32'(ack_o), 32'd0);
            cycle();
            req_i = 3'b011;
        end
        ack_i = 1;
        #1;
        chk("t3_ack", 32'(ack_o), 32'b010);
        cycle();
        req_i = '0; resp_i = 1;
        #1;
        chk("t3_resp", 32'(resp_o), 32'b010);
        cycle();
        resp_i = 0;

        // T4: four reads fill the ID FIFO, then responses route in order.
        for (int k = 0; k < N; k++) set_m(k, 1'b0, 32'h2000_0000 + 32'(16 * k));
        for (int i = 0; i < 4; i++) begin
            req_i = N'(1 << t4_owner[i]);
            #1;
            chk("t4_fill_ack", 32'(ack_o), 32'(req_i));
            cycle();
        end
        req_i = '1;
        #1;
        chk("t4_full_req", 32'(req_o), 32'd0);
        chk("t4_full_ack", 32'(ack_o), 32'd0);
        cycle();
        rdata_bi = 32'hdead_beef;
        resp_i = 1;
        req_i = 3'b001;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("t4_resp", 32'(resp_o), 32'(1 << t4_owner[i]));
            chk("t4_rdata", rdata_bo, 32'hdead_beef);
            if (i == 0) chk("t4_pop_no_unblock", 32'(req_o), 32'd0);
            cycle();
            req_i = '0;
        end

        // T5: stray response sets a sticky error.
        #1;
        chk("t5_err_before", 32'(err_o), 32'd0);
        cycle();
        resp_i = 0;
        repeat (3) begin
            #1;
            chk("t5_err_sticky", 32'(err_o), 32'd1);
            cycle();
        end
        rst_i = 1;
        cycle();
        rst_i = 0;
        #1;
        chk("t5_err_cleared", 32'(err_o), 32'd0);

        // T6: rr_ptr moved to 1, then everyone requests.
        req_i = 3'b001; we_i = '1;
        cycle();
        req_i = 3'b111;
        #1;
        chk("t6_ack", 32'(ack_o), 32'(t6_ack));
        cycle();

        // Randomized traffic; a held master keeps requesting.
        for (int n = 0; n < 500; n++) begin
            rst_i    = ($urandom_range(0, 99) == 0);
            req_i    = N'($urandom_range(0, 7));
            if (m_hold) req_i[m_held] = 1'b1;
            we_i     = N'($urandom_range(0, 7));
            addr_bi  = {$urandom, $urandom, $urandom};
            be_bi    = 12'($urandom_range(0, 4095));
            wdata_bi = {$urandom, $urandom, $urandom};
            ack_i    = ($urandom_range(0, 2) != 0);
            resp_i   = (m_q.size() > 0) ? 1'($urandom_range(0, 1)) : ($urandom_range(0, 31) == 0);
            rdata_bi = $urandom;
            cycle();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
